// File: rtl/nnoc_pkg.sv
// Shared constants and state type for the 4x4 matmul tile sequencing logic.
package nnoc_pkg;
   localparam int N              = 4;
   localparam int FLUSH_CYCLES   = 2*N - 2;
   localparam int CAPTURE_CYCLES = 2*N - 1;
   localparam int BUF_DEPTH      = N*N;
   localparam int ROW_W          = $clog2(N);
   localparam int IDX_W          = $clog2(BUF_DEPTH);
   localparam int PH_W           = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_FEED,
      ST_FLUSH,
      ST_CAPTURE,
      ST_DRAIN
   } drain_state_t;

   // Transposed order is 4*(i mod 4) + i/4, which is a swap of the two index halves.
   function automatic logic [IDX_W-1:0] drain_index(input logic [IDX_W-1:0] i, input logic tr);
      return tr ? {i[ROW_W-1:0], i[IDX_W-1:ROW_W]} : i;
   endfunction
endpackage

// File: rtl/result_capture_bank.sv
// 16-entry result register file: one write port per array column, one indexed read.
module result_capture_bank
   import nnoc_pkg::*;
#(
   parameter int ACCUMULATE = 32
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [N-1:0]                   wr_en,
   input  logic [N-1:0][ROW_W-1:0]        wr_row,
   input  logic [N-1:0][ACCUMULATE-1:0]   wr_data,
   input  logic [IDX_W-1:0]               rd_idx,
   output logic [ACCUMULATE-1:0]          rd_data
);

   logic [ACCUMULATE-1:0] mem [BUF_DEPTH];

   // Column c owns entries 4c..4c+3, so parallel writes never collide.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem <= '{default: '0};
      end else begin
         for (int c = 0; c < N; c++) begin
            if (wr_en[c]) mem[{ROW_W'(c), wr_row[c]}] <= wr_data[c];
         end
      end
   end

   assign rd_data = mem[rd_idx];

endmodule

// File: rtl/result_drain_ctrl.sv
// Tile sequencer: clear, feed, flush the skew, capture skewed columns, drain as a stream.
module result_drain_ctrl
   import nnoc_pkg::*;
#(
   parameter int ACCUMULATE = 32,
   parameter int KW         = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic [KW-1:0]                  k_len,
   input  logic                           transpose_out,
   input  logic [N-1:0][ACCUMULATE-1:0]   col_data,
   output logic                           array_clear,
   output logic                           feed_en,
   output logic                           busy,
   output logic [ACCUMULATE-1:0]          out_data,
   output logic [IDX_W-1:0]               out_idx,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic                           done
);

   drain_state_t            state, state_nxt;
   logic [KW-1:0]           feed_cnt;
   logic [PH_W-1:0]         phase_cnt;
   logic [IDX_W-1:0]        drain_cnt;
   logic                    tr_q;
   logic                    done_q;
   logic [N-1:0]            wr_en;
   logic [N-1:0][ROW_W-1:0] wr_row;
   logic [IDX_W-1:0]        rd_idx;
   logic [ACCUMULATE-1:0]   rd_data;
   logic                    accept;

   assign accept = start && (k_len != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         feed_cnt  <= '0;
         phase_cnt <= '0;
         drain_cnt <= '0;
         tr_q      <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  feed_cnt <= k_len;
                  tr_q     <= transpose_out;
               end
            end
            ST_FEED:    feed_cnt <= feed_cnt - 1'b1;
            // Flush and capture share one phase counter; it restarts at each phase boundary.
            ST_FLUSH:   phase_cnt <= (phase_cnt == PH_W'(FLUSH_CYCLES - 1)) ? '0 : phase_cnt + 1'b1;
            ST_CAPTURE: phase_cnt <= (phase_cnt == PH_W'(CAPTURE_CYCLES - 1)) ? '0 : phase_cnt + 1'b1;
            ST_DRAIN: begin
               if (out_ready) begin
                  drain_cnt <= drain_cnt + 1'b1;
                  if (drain_cnt == IDX_W'(BUF_DEPTH - 1)) done_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt   = state;
      array_clear = 1'b0;
      feed_en     = 1'b0;
      out_valid   = 1'b0;
      case (state)
         ST_IDLE:    if (accept) state_nxt = ST_CLEAR;
         ST_CLEAR: begin
            array_clear = 1'b1;
            state_nxt   = ST_FEED;
         end
         ST_FEED: begin
            feed_en = 1'b1;
            if (feed_cnt == KW'(1)) state_nxt = ST_FLUSH;
         end
         ST_FLUSH:   if (phase_cnt == PH_W'(FLUSH_CYCLES - 1)) state_nxt = ST_CAPTURE;
         ST_CAPTURE: if (phase_cnt == PH_W'(CAPTURE_CYCLES - 1)) state_nxt = ST_DRAIN;
         ST_DRAIN: begin
            out_valid = 1'b1;
            if (out_ready && drain_cnt == IDX_W'(BUF_DEPTH - 1)) state_nxt = ST_IDLE;
         end
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // Column c carries result row t-c while c <= t <= c+3 of the capture window.
   always_comb begin
      wr_en  = '0;
      wr_row = '0;
      for (int c = 0; c < N; c++) begin
         if (state == ST_CAPTURE && phase_cnt >= PH_W'(c) && phase_cnt <= PH_W'(c + N - 1)) begin
            wr_en[c]  = 1'b1;
            wr_row[c] = ROW_W'(phase_cnt - PH_W'(c));
         end
      end
   end

   assign rd_idx   = drain_index(drain_cnt, tr_q);
   assign out_idx  = (state == ST_DRAIN) ? rd_idx : '0;
   assign out_data = (state == ST_DRAIN) ? rd_data : '0;
   assign busy     = (state != ST_IDLE);
   assign done     = done_q;

   result_capture_bank #(
      .ACCUMULATE (ACCUMULATE)
   ) u_bank (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_row  (wr_row),
      .wr_data (col_data),
      .rd_idx  (rd_idx),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_result_drain_ctrl.sv
// Bench for result_drain_ctrl: timeline reference model plus directed and random tiles.
module tb_result_drain_ctrl;
   localparam int AW = 32;
   localparam int KW = 8;

   logic               clk = 1'b0;
   logic               reset;
   logic               start;
   logic [KW-1:0]      k_len;
   logic               transpose_out;
   logic [3:0][AW-1:0] col_data;
   logic               array_clear, feed_en, busy, out_valid, done, out_ready;
   logic [AW-1:0]      out_data;
   logic [3:0]         out_idx;

   always #5 clk = ~clk;

   result_drain_ctrl #(.ACCUMULATE(AW), .KW(KW)) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .k_len         (k_len),
      .transpose_out (transpose_out),
      .col_data      (col_data),
      .array_clear   (array_clear),
      .feed_en       (feed_en),
      .busy          (busy),
      .out_data      (out_data),
      .out_idx       (out_idx),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .done          (done)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: a tile is a timeline of cycles j since acceptance plus a handshake count.
   bit          m_active = 0, m_tr = 0, m_done = 0;
   int          m_j = 0, m_k = 0, m_drained = 0;
   logic [31:0] m_buf [16];
   initial for (int e = 0; e < 16; e++) m_buf[e] = '0;

   function automatic int exp_index(input int d, input bit tr);
      return tr ? 4 * (d % 4) + d / 4 : d;
   endfunction

   always @(posedge clk) begin : model
      bit act, tr, dn;
      int j, k, d, t;
      logic [31:0] b [16];
      act = m_active; tr = m_tr; j = m_j; k = m_k; d = m_drained; b = m_buf; dn = 0;
      if (reset) begin
         act = 0; j = 0; d = 0;
         for (int e = 0; e < 16; e++) b[e] = '0;
      end else if (!act) begin
         if (start && k_len != 0) begin
            act = 1; j = 0; k = int'(k_len); tr = transpose_out; d = 0;
         end
      end else begin
         if (j >= k + 7 && j <= k + 13) begin
            t = j - k - 7;
            for (int c = 0; c < 4; c++)
               if (c <= t && t <= c + 3) b[4 * c + t - c] = col_data[c];
         end
         if (j >= k + 14 && out_ready === 1'b1) begin
            d++;
            if (d == 16) begin act = 0; dn = 1; end
         end
         j++;
      end
      m_active  <= act; m_tr <= tr; m_j <= j; m_k <= k;
      m_drained <= d; m_buf <= b; m_done <= dn;
   end

   bit chk_en = 0;
   always @(negedge clk) begin : compare
      bit ev;
      int ix;
      if (chk_en) begin
         ev = m_active && m_j >= m_k + 14;
         check("busy", busy, m_active);
         check("array_clear", array_clear, m_active && m_j == 0);
         check("feed_en", feed_en, m_active && m_j >= 1 && m_j <= m_k);
         check("out_valid", out_valid, ev);
         check("done", done, m_done);
         if (ev) begin
            ix = exp_index(m_drained, m_tr);
            check("out_idx", out_idx, ix);
            check("out_data", out_data, m_buf[ix]);
         end
      end
   end

   // Monitors sample pre-edge values at the active edge.
   int          cyc = 0, feed_n = 0, clr_n = 0;
   int          hs_idx[$];
   logic [31:0] hs_dat[$];
   bit          stalled = 0;
   logic [3:0]  st_idx;
   logic [31:0] st_dat;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (cyc > 60000) begin
         $display("FAIL watchdog: cycle %0d, limit %0d", cyc, 60000);
         $fatal(1);
      end
      if (feed_en === 1'b1) feed_n <= feed_n + 1;
      if (array_clear === 1'b1) clr_n <= clr_n + 1;
      if (chk_en && stalled && out_valid === 1'b1 && reset === 1'b0) begin
         check("stall_idx", out_idx, st_idx);
         check("stall_data", out_data, st_dat);
      end
      stalled <= (out_valid === 1'b1 && out_ready === 1'b0 && reset === 1'b0);
      st_idx  <= out_idx;
      st_dat  <= out_data;
      if (out_valid === 1'b1 && out_ready === 1'b1 && reset === 1'b0) begin
         hs_idx.push_back(int'(out_idx));
         hs_dat.push_back(out_data);
      end
   end

   int pat_mode = 0, rdy_mode = 0, rdy_ph = 0;

   task automatic step();
      @(negedge clk);
      rdy_ph++;
      for (int c = 0; c < 4; c++)
         col_data[c] = (pat_mode != 0) ? 32'(32'h100 * c + (m_j - m_k - 7)) : $urandom;
      case (rdy_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = (rdy_ph % 3 == 0);
         default: out_ready = ($urandom_range(3) != 0);
      endcase
   endtask

   task automatic clear_logs();
      hs_idx.delete();
      hs_dat.delete();
      feed_n = 0;
      clr_n  = 0;
   endtask

   task automatic do_start(input int k, input bit tr);
      start = 1'b1; k_len = KW'(k); transpose_out = tr;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int bound);
      int n = 0;
      while (done !== 1'b1 && n < bound) begin step(); n++; end
      if (done !== 1'b1) begin
         n_cmp++; n_bad++;
         $display("FAIL %s_timeout: done not seen within %0d cycles", nm, bound);
      end
   endtask

   task automatic check_seq(input string nm, input bit tr, input bit pat);
      int e;
      check({nm, "_hs_count"}, hs_idx.size(), 16);
      for (int i = 0; i < 16 && i < hs_idx.size(); i++) begin
         e = exp_index(i, tr);
         check($sformatf("%s_idx%0d", nm, i), hs_idx[i], e);
         if (pat) check($sformatf("%s_data%0d", nm, i), hs_dat[i], 32'h100 * (e / 4) + (e / 4 + e % 4));
      end
   endtask

   initial begin
      int s0, n;
      reset = 1'b1; start = 1'b0; k_len = '0; transpose_out = 1'b0; out_ready = 1'b1;
      col_data = '0;
      step(); step();
      reset = 1'b0;
      chk_en = 1;
      check("rst_busy", busy, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_done", done, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_idx", out_idx, 0);

      // Basic tile, index order.
      pat_mode = 1; rdy_mode = 0;
      step(); clear_logs();
      s0 = cyc;
      do_start(3, 0);
      check("basic_clear_after_start", array_clear, 1);
      wait_done("basic", 100);
      check("basic_latency", cyc - s0, 34);
      check("basic_feed_cycles", feed_n, 3);
      check("basic_clear_cycles", clr_n, 1);
      check_seq("basic", 0, 1);

      // Transposed drain.
      step(); clear_logs();
      do_start(3, 1);
      wait_done("transpose", 100);
      check_seq("transpose", 1, 1);

      // Backpressure with ignored starts during FEED and DRAIN.
      rdy_mode = 1;
      step(); clear_logs();
      do_start(5, 0);
      step();
      start = 1'b1; k_len = 8'd9; transpose_out = 1'b1;
      step();
      start = 1'b0;
      n = 0;
      while (out_valid !== 1'b1 && n < 100) begin step(); n++; end
      check("bp_reached_drain", out_valid, 1);
      start = 1'b1;
      step();
      start = 1'b0;
      wait_done("backpressure", 200);
      check("bp_feed_cycles", feed_n, 5);
      check_seq("backpressure", 0, 1);

      // Zero-length start is ignored.
      rdy_mode = 0;
      do_start(0, 0);
      check("klen0_busy", busy, 0);
      step(); step();
      check("klen0_busy_later", busy, 0);

      // Reset after five drained words, then a k_len=1 tile.
      clear_logs();
      do_start(4, 0);
      n = 0;
      while (hs_idx.size() < 5 && n < 100) begin step(); n++; end
      check("mid_drain_words", hs_idx.size(), 5);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_out_data", out_data, 0);
      check("mid_rst_out_idx", out_idx, 0);
      step(); clear_logs();
      s0 = cyc;
      do_start(1, 0);
      wait_done("after_reset", 100);
      check("after_reset_latency", cyc - s0, 32);
      check_seq("after_reset", 0, 1);

      // Back-to-back: start on the done cycle.
      clear_logs();
      start = 1'b1; k_len = 8'd2; transpose_out = 1'b0;
      step();
      start = 1'b0;
      check("b2b_clear", array_clear, 1);
      step(); clear_logs();
      n = 0;
      while (done !== 1'b1 && n < 100) begin step(); n++; end
      start = 1'b1; k_len = 8'd1;
      step();
      start = 1'b0;
      check("b2b_clear_after_done", array_clear, 1);
      wait_done("b2b_second", 100);

      // Random traffic against the model.
      pat_mode = 0; rdy_mode = 2;
      for (int i = 0; i < 4000; i++) begin
         step();
         start         = ($urandom_range(7) == 0);
         k_len         = KW'($urandom_range(12));
         transpose_out = $urandom_range(1);
         reset         = ($urandom_range(399) == 0);
      end
      start = 1'b0; reset = 1'b0; rdy_mode = 0;
      n = 0;
      while (busy !== 1'b0 && n < 200) begin step(); n++; end
      check("final_idle", busy, 0);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/result_drain_ctrl.md
# result_drain_ctrl

Sequencer for one 4x4 weight-stationary matmul tile on a core. It clears the accumulators and gates the operand feeder for `k_len` cycles. It waits out the array skew, then captures the four skewed column result streams into a 16-entry buffer using explicit timing instead of change detection. Finally it drains the buffer as a valid/ready stream toward the router, with optional transposed ordering so the router receives XWᵀ layout.

## Interface
- `ACCUMULATE`, 32, accumulator/result word width
- `KW`, 8, width of the `k_len` field
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `start`  in  1  begin a tile; sampled only in IDLE
- `k_len`  in  KW  reduction length; latched on accepted start
- `transpose_out`  in  1  drain order select; latched on accepted start
- `col_data`  in  ACCUMULATE x 4  per-column result ports from the array
- `array_clear`  out  1  one-cycle accumulator clear
- `feed_en`  out  1  operand feeder enable
- `busy`  out  1  high in every state except IDLE
- `out_data`  out  ACCUMULATE  drained result word
- `out_idx`  out  4  buffer index of `out_data`
- `out_valid`  out  1  drain word valid
- `out_ready`  in  1  downstream accept
- `done`  out  1  one-cycle pulse after the last drain handshake

## Operation
- States: IDLE, CLEAR, FEED, FLUSH, CAPTURE, DRAIN.
- IDLE -> CLEAR on `start` with `k_len` != 0. Start with `k_len` == 0 is ignored. Start while busy is ignored.
- CLEAR lasts 1 cycle, with `array_clear`=1. It then goes to FEED.
- FEED lasts exactly `k_len` cycles, with `feed_en`=1. It then goes to FLUSH.
- FLUSH lasts FLUSH_CYCLES = 6 cycles (2N-2), with all strobes low.
- CAPTURE lasts 7 cycles (2N-1), counted by capture counter t = 0..6.
  - Column c is valid when c <= t <= c+3.
  - At those cycles, `col_data[c]` is written to buf[4c + (t-c)].
  - Writes for all valid columns in a cycle occur in parallel.
- DRAIN issues 16 words, with drain counter i = 0..15.
  - `transpose_out`=0: index = i.
  - `transpose_out`=1: index = 4·(i mod 4) + i/4.
  - `out_idx` is the index; `out_data` is buf[index].
- Drain handshake:
  - `out_valid`=1 throughout DRAIN.
  - i advances only when `out_valid`&&`out_ready`.
  - `out_data` and `out_idx` are held stable while stalled.
- After the handshake at i=15, the next state is IDLE and `done`=1 for that first IDLE cycle.
- Arithmetic: no arithmetic on data. The FEED counter is KW bits and counts down from `k_len`. Widths are exact, with no wrap inside a phase.

## Timing
- All outputs are Moore-decoded from registered state and counters. There is no combinational path from inputs to outputs except `out_ready`, which has no output path at all.
- Reset values: state=IDLE; `array_clear`, `feed_en`, `busy`, `out_valid`, `done` = 0; `out_data`, `out_idx` = 0; all counters and buf entries = 0.
- With start accepted at edge E0:
  - CLEAR occupies cycle E0+1.
  - FEED occupies E0+2 .. E0+k_len+1.
  - FLUSH occupies the next 6 cycles.
  - CAPTURE occupies the next 7 cycles.
  - First `out_valid` comes k_len+15 cycles after E0.
- Minimum total latency with `out_ready` tied high: start to `done` = k_len+31 cycles.
- Reset at any point, including mid-CAPTURE or mid-DRAIN, returns to IDLE with reset values on the next edge. Reset beats a simultaneous `start`.
- `start` asserted on the same cycle `done` pulses is accepted, because the controller is in IDLE.

## Structure
- The shared package `nnoc_pkg` holds:
  - N=4
  - FLUSH_CYCLES=6
  - CAPTURE_CYCLES=7
  - BUF_DEPTH=16
  - the `drain_state_t` enum
- Sub-module `result_capture_bank`: the 16 x ACCUMULATE register file. It has 4 column write ports with per-column enable and row select, plus one indexed read mux. The FSM and counters stay in `result_drain_ctrl`.

## Test plan
- Basic tile: `k_len`=3, `col_data[c]` = 0x100·c + t during CAPTURE, `out_ready`=1.
  - `array_clear` appears 1 cycle after start.
  - `feed_en` is high for exactly 3 cycles.
  - Drain outputs buf[4c+r] = 0x100·c + (c+r) in index order 0..15.
  - `done` comes at start+34.
- Transpose: same stimulus with `transpose_out`=1. `out_idx` sequence is 0,4,8,12,1,5,…,15, with matching data.
- Backpressure: `out_ready` toggles 1,0,0,1,… during DRAIN.
  - Data and index stay stable across stalls.
  - Exactly 16 handshakes occur before `done`.
- Ignored starts:
  - Start with `k_len`=0 leaves `busy`=0.
  - Start pulses during FEED and DRAIN have no effect on counts or sequence.
- Reset mid-DRAIN after 5 words:
  - Next cycle: `busy`=0, `out_valid`=0, buf reads 0.
  - A new tile with `k_len`=1 completes normally.
- Back-to-back: start asserted on the `done` cycle is accepted, and CLEAR follows next cycle.
